// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode: a circular buffer
// accepting up to two entries and releasing up to two entries per cycle.
module inst_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid_1,
  input  logic                     in_valid_2,
  input  logic [31:0]              in_pc_1,
  input  logic [31:0]              in_pc_2,
  input  logic [31:0]              in_instr_1,
  input  logic [31:0]              in_instr_2,
  input  logic                     in_adel_1,
  input  logic                     in_adel_2,
  output logic                     in_ready,
  output logic                     out_valid_1,
  output logic                     out_valid_2,
  output logic [31:0]              out_pc_1,
  output logic [31:0]              out_pc_2,
  output logic [31:0]              out_instr_1,
  output logic [31:0]              out_instr_2,
  output logic                     out_adel_1,
  output logic                     out_adel_2,
  input  logic                     deq_1,
  input  logic                     deq_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          adel_mem_q  [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    nenq, ndeq;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Readiness looks only at registered occupancy so fetch never depends on decode.
  assign in_ready    = (count_q <= READY_MAX);
  assign out_valid_1 = (count_q != '0);
  assign out_valid_2 = (count_q >= CW'(2));
  assign count       = count_q;

  assign out_pc_1    = pc_mem_q[head_q];
  assign out_pc_2    = pc_mem_q[head_p1];
  assign out_instr_1 = instr_mem_q[head_q];
  assign out_instr_2 = instr_mem_q[head_p1];
  assign out_adel_1  = adel_mem_q[head_q];
  assign out_adel_2  = adel_mem_q[head_p1];

  always_comb begin
    nenq = 2'd0;
    if (in_valid_1 && in_ready) begin
      nenq = in_valid_2 ? 2'd2 : 2'd1;
    end
    ndeq = 2'd0;
    if (deq_1 && out_valid_1) begin
      ndeq = (deq_2 && out_valid_2) ? 2'd2 : 2'd1;
    end
    head_d  = head_q + AW'(ndeq);
    tail_d  = tail_q + AW'(nenq);
    count_d = count_q + CW'(nenq) - CW'(ndeq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (nenq != 2'd0) begin
        pc_mem_q[tail_q]    <= in_pc_1;
        instr_mem_q[tail_q] <= in_instr_1;
        adel_mem_q[tail_q]  <= in_adel_1;
      end
      if (nenq == 2'd2) begin
        pc_mem_q[tail_p1]    <= in_pc_2;
        instr_mem_q[tail_p1] <= in_instr_2;
        adel_mem_q[tail_p1]  <= in_adel_2;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed table-driven bench for inst_queue (DEPTH = 8) plus hand-written
// sequences for same-cycle readiness and enqueue latency.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid_1, in_valid_2;
  logic [31:0] in_pc_1, in_pc_2, in_instr_1, in_instr_2;
  logic        in_adel_1, in_adel_2;
  logic        in_ready, out_valid_1, out_valid_2;
  logic [31:0] out_pc_1, out_pc_2, out_instr_1, out_instr_2;
  logic        out_adel_1, out_adel_2;
  logic        deq_1, deq_2;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid_1(in_valid_1), .in_valid_2(in_valid_2),
    .in_pc_1(in_pc_1), .in_pc_2(in_pc_2),
    .in_instr_1(in_instr_1), .in_instr_2(in_instr_2),
    .in_adel_1(in_adel_1), .in_adel_2(in_adel_2),
    .in_ready(in_ready),
    .out_valid_1(out_valid_1), .out_valid_2(out_valid_2),
    .out_pc_1(out_pc_1), .out_pc_2(out_pc_2),
    .out_instr_1(out_instr_1), .out_instr_2(out_instr_2),
    .out_adel_1(out_adel_1), .out_adel_2(out_adel_2),
    .deq_1(deq_1), .deq_2(deq_2),
    .count(count)
  );

  // Instruction word and adel flag are derived from the PC so every entry is distinct.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1234_5678;
  endfunction

  function automatic logic adel_of(input logic [31:0] pc);
    return ^pc[5:2];
  endfunction

  typedef struct {
    string       name;
    logic        rst, fl, v1, v2, d1, d2;
    logic [31:0] pc1, pc2;
    logic [3:0]  e_cnt;
    logic        e_rdy, e_ov1, e_ov2;
    logic [31:0] e_pc1, e_pc2;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rst, input logic fl,
                     input logic v1, input logic v2,
                     input logic [31:0] pc1, input logic [31:0] pc2,
                     input logic d1, input logic d2,
                     input logic [3:0] e_cnt, input logic e_rdy,
                     input logic e_ov1, input logic e_ov2,
                     input logic [31:0] e_pc1, input logic [31:0] e_pc2);
    vec_t v;
    v.name = nm; v.rst = rst; v.fl = fl; v.v1 = v1; v.v2 = v2;
    v.pc1 = pc1; v.pc2 = pc2; v.d1 = d1; v.d2 = d2;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ov1 = e_ov1; v.e_ov2 = e_ov2;
    v.e_pc1 = e_pc1; v.e_pc2 = e_pc2;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic v1, input logic v2,
                       input logic [31:0] pc1, input logic [31:0] pc2,
                       input logic d1, input logic d2);
    reset = rst; flush = fl;
    in_valid_1 = v1; in_valid_2 = v2;
    in_pc_1 = pc1; in_pc_2 = pc2;
    in_instr_1 = instr_of(pc1); in_instr_2 = instr_of(pc2);
    in_adel_1 = adel_of(pc1); in_adel_2 = adel_of(pc2);
    deq_1 = d1; deq_2 = d2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    //   name        rst fl  v1  v2  pc1           pc2           d1  d2  cnt  rdy ov1 ov2 e_pc1         e_pc2
    add("reset",     1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("ord_enq1",  0, 0, 1, 1, 32'hBFC00000, 32'hBFC00004, 0, 0, 4'd2, 1, 1, 1, 32'hBFC00000, 32'hBFC00004);
    add("ord_enq2",  0, 0, 1, 1, 32'hBFC00008, 32'hBFC0000C, 1, 1, 4'd2, 1, 1, 1, 32'hBFC00008, 32'hBFC0000C);
    add("ord_drain", 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("fill_rst",  1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("fill_1",    0, 0, 1, 1, 32'h000000A0, 32'h000000A4, 0, 0, 4'd2, 1, 1, 1, 32'h000000A0, 32'h000000A4);
    add("fill_2",    0, 0, 1, 1, 32'h000000A8, 32'h000000AC, 0, 0, 4'd4, 1, 1, 1, 32'h000000A0, 32'h000000A4);
    add("fill_3",    0, 0, 1, 1, 32'h000000B0, 32'h000000B4, 0, 0, 4'd6, 1, 1, 1, 32'h000000A0, 32'h000000A4);
    add("fill_4",    0, 0, 1, 1, 32'h000000B8, 32'h000000BC, 0, 0, 4'd8, 0, 1, 1, 32'h000000A0, 32'h000000A4);
    add("full_drop", 0, 0, 1, 1, 32'h000000C0, 32'h000000C4, 0, 0, 4'd8, 0, 1, 1, 32'h000000A0, 32'h000000A4);
    add("deq_to7",   0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 4'd7, 0, 1, 1, 32'h000000A4, 32'h000000A8);
    add("deq_to6",   0, 0, 0, 0, 32'h0,        32'h0,        1, 0, 4'd6, 1, 1, 1, 32'h000000A8, 32'h000000AC);
    add("wrap_enq",  0, 0, 1, 1, 32'h000000C0, 32'h000000C4, 0, 0, 4'd8, 0, 1, 1, 32'h000000A8, 32'h000000AC);
    add("wrap_d1",   0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd6, 1, 1, 1, 32'h000000B0, 32'h000000B4);
    add("wrap_d2",   0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd4, 1, 1, 1, 32'h000000B8, 32'h000000BC);
    add("wrap_d3",   0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd2, 1, 1, 1, 32'h000000C0, 32'h000000C4);
    add("wrap_d4",   0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("sim_pre1",  0, 0, 1, 1, 32'h000000D0, 32'h000000D4, 0, 0, 4'd2, 1, 1, 1, 32'h000000D0, 32'h000000D4);
    add("sim_pre2",  0, 0, 1, 0, 32'h000000D8, 32'h0,        0, 0, 4'd3, 1, 1, 1, 32'h000000D0, 32'h000000D4);
    add("sim_e2d1",  0, 0, 1, 1, 32'h000000DC, 32'h000000E0, 1, 0, 4'd4, 1, 1, 1, 32'h000000D4, 32'h000000D8);
    add("sim_d1",    0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd2, 1, 1, 1, 32'h000000DC, 32'h000000E0);
    add("sim_d2",    0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("ill_v2",    0, 0, 0, 1, 32'h0,        32'h000000F0, 0, 0, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("ill_pre",   0, 0, 1, 1, 32'h000000F4, 32'h000000F8, 0, 0, 4'd2, 1, 1, 1, 32'h000000F4, 32'h000000F8);
    add("ill_d2",    0, 0, 0, 0, 32'h0,        32'h0,        0, 1, 4'd2, 1, 1, 1, 32'h000000F4, 32'h000000F8);
    add("ill_drain", 0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("ill_d1e",   0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("fl_pre1",   0, 0, 1, 1, 32'h00000100, 32'h00000104, 0, 0, 4'd2, 1, 1, 1, 32'h00000100, 32'h00000104);
    add("fl_pre2",   0, 0, 1, 1, 32'h00000108, 32'h0000010C, 0, 0, 4'd4, 1, 1, 1, 32'h00000100, 32'h00000104);
    add("fl_pre3",   0, 0, 1, 0, 32'h00000110, 32'h0,        0, 0, 4'd5, 1, 1, 1, 32'h00000100, 32'h00000104);
    add("flush",     0, 1, 1, 1, 32'h00000200, 32'h00000204, 1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("fl_idle",   0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("fl_after",  0, 0, 1, 1, 32'h00000300, 32'h00000304, 0, 0, 4'd2, 1, 1, 1, 32'h00000300, 32'h00000304);
    add("fl_drain",  0, 0, 0, 0, 32'h0,        32'h0,        1, 1, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("rs_pre1",   0, 0, 1, 1, 32'h00000400, 32'h00000404, 0, 0, 4'd2, 1, 1, 1, 32'h00000400, 32'h00000404);
    add("rs_pre2",   0, 0, 1, 1, 32'h00000408, 32'h0000040C, 0, 0, 4'd4, 1, 1, 1, 32'h00000400, 32'h00000404);
    add("rs_pre3",   0, 0, 1, 1, 32'h00000410, 32'h00000414, 0, 0, 4'd6, 1, 1, 1, 32'h00000400, 32'h00000404);
    add("rs_mid",    1, 1, 1, 1, 32'h00000418, 32'h0000041C, 1, 0, 4'd0, 1, 0, 0, 32'h0,        32'h0);
    add("rs_enq",    0, 0, 1, 0, 32'h80000000, 32'h0,        0, 0, 4'd1, 1, 1, 0, 32'h80000000, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].v1, vecs[i].v2,
            vecs[i].pc1, vecs[i].pc2, vecs[i].d1, vecs[i].d2);
      step();
      chk({vecs[i].name, ".count"},    32'(count),       32'(vecs[i].e_cnt));
      chk({vecs[i].name, ".in_ready"}, 32'(in_ready),    32'(vecs[i].e_rdy));
      chk({vecs[i].name, ".valid_1"},  32'(out_valid_1), 32'(vecs[i].e_ov1));
      chk({vecs[i].name, ".valid_2"},  32'(out_valid_2), 32'(vecs[i].e_ov2));
      if (vecs[i].e_ov1) begin
        chk({vecs[i].name, ".pc_1"},    out_pc_1,        vecs[i].e_pc1);
        chk({vecs[i].name, ".instr_1"}, out_instr_1,     instr_of(vecs[i].e_pc1));
        chk({vecs[i].name, ".adel_1"},  32'(out_adel_1), 32'(adel_of(vecs[i].e_pc1)));
      end
      if (vecs[i].e_ov2) begin
        chk({vecs[i].name, ".pc_2"},    out_pc_2,        vecs[i].e_pc2);
        chk({vecs[i].name, ".instr_2"}, out_instr_2,     instr_of(vecs[i].e_pc2));
        chk({vecs[i].name, ".adel_2"},  32'(out_adel_2), 32'(adel_of(vecs[i].e_pc2)));
      end
    end

    // A dequeue in the same cycle does not make a full queue ready.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h500 + 32'(k * 8), 32'h504 + 32'(k * 8), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0600, 32'h0000_0604, 1'b1, 1'b0);
    #1;
    chk("nocredit.in_ready", 32'(in_ready), 32'd0);
    step();
    chk("nocredit.count", 32'(count), 32'd7);
    chk("nocredit.pc_1",  out_pc_1,   32'h0000_0504);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step();
    chk("nocredit.last_pc", out_pc_1, 32'h0000_051C);
    chk("nocredit.last_n",  32'(count), 32'd1);

    // Entries become visible only after the enqueue edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0000_0704, 1'b1, 1'b1);
    #1;
    chk("nobypass.pre_valid", 32'(out_valid_1), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("nobypass.post_valid", 32'(out_valid_1), 32'd1);
    chk("nobypass.post_pc",    out_pc_1,         32'h0000_0700);
    chk("nobypass.post_count", 32'(count),       32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
